// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side offer and decode-side head/field signals of the decode queue
interface decode_queue_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 3
);
  logic              push, pop, flush, br_taken;
  logic [WORD_W-1:0] instru, PC, nPC;
  logic              full, valid, br_taken_out, halt, halt_seen;
  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] instr, jPC, nPC_out, shamt;
  logic [4:0]        rs, rt;
  logic [15:0]       imm16;
  logic [25:0]       jaddr;
  modport master (
    output push, instru, PC, nPC, br_taken, pop, flush,
    input  full, valid, count, instr, jPC, nPC_out, br_taken_out,
           rs, rt, shamt, imm16, jaddr, halt, halt_seen
  );
  modport slave (
    input  push, instru, PC, nPC, br_taken, pop, flush,
    output full, valid, count, instr, jPC, nPC_out, br_taken_out,
           rs, rt, shamt, imm16, jaddr, halt, halt_seen
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: circular fetch-to-decode buffer with head field decode and halt lockout
module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic          CLK,
  input logic          RST,
  decode_queue_if.slave q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WORD_W-1:0] ins_m [DEPTH];
  logic [WORD_W-1:0] pc_m  [DEPTH];
  logic [WORD_W-1:0] npc_m [DEPTH];
  logic              br_m  [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CNT_W-1:0]  cnt;
  logic              hs, full_i, valid_i, do_push, do_pop;
  logic [WORD_W-1:0] h_ins;
  always_comb begin
    full_i  = cnt == CNT_W'(DEPTH);
    valid_i = cnt != '0;
    do_pop  = q.pop & valid_i & ~q.flush;
    // a full queue still accepts when the head leaves in the same cycle
    do_push = q.push & ~q.flush & ~hs & (~full_i | do_pop);
  end
  always_ff @(posedge CLK) begin
    if (RST || q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      hs   <= 1'b0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop) head <= head + PW'(1);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push && q.instru[31:26] == 6'h3f) hs <= 1'b1;
    end
  end
  // entries are never cleared; every head output is gated by valid instead
  always_ff @(posedge CLK) begin
    if (!RST && do_push) begin
      ins_m[tail] <= q.instru;
      pc_m[tail]  <= q.PC;
      npc_m[tail] <= q.nPC;
      br_m[tail]  <= q.br_taken;
    end
  end
  always_comb begin
    h_ins          = valid_i ? ins_m[head] : '0;
    q.full         = full_i;
    q.valid        = valid_i;
    q.count        = cnt;
    q.halt_seen    = hs;
    q.instr        = h_ins;
    q.jPC          = valid_i ? pc_m[head] : '0;
    q.nPC_out      = valid_i ? npc_m[head] : '0;
    q.br_taken_out = valid_i ? br_m[head] : 1'b0;
    q.rs           = h_ins[25:21];
    q.rt           = h_ins[20:16];
    q.shamt        = WORD_W'(h_ins[10:6]);
    q.imm16        = h_ins[15:0];
    q.jaddr        = h_ins[25:0];
    q.halt         = valid_i & (h_ins[31:26] == 6'h3f);
  end
endmodule
